// File: rtl/ma_dmem_arbiter_if.sv
// Bus bundle between the two MA_DMEM requesters (PE, LD), the arbiter and the memory.
//
// Handshake: a requester raises *_req with *_we/*_addr/*_wdata (and ld_last) stable
// and holds them until it sees *_gnt; the transfer happens on the clock edge where
// req & gnt are both 1, and the requester may change its fields from the next cycle.
// Read data returns exactly one cycle after the granting edge, flagged by *_rvalid.
interface ma_dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              pe_req;
    logic              pe_we;
    logic [ADDR_W-1:0] pe_addr;
    logic [DATA_W-1:0] pe_wdata;
    logic              pe_gnt;
    logic              pe_rvalid;
    logic [DATA_W-1:0] pe_rdata;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_last;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    logic              busy;
    logic              state_dbg;   // arbiter FSM state: 0=IDLE, 1=LD_LOCK

    // Requester and memory side
    modport master (
        output pe_req, pe_we, pe_addr, pe_wdata,
        input  pe_gnt, pe_rvalid, pe_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_last,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout,
        input  busy, state_dbg
    );

    // Arbiter side
    modport slave (
        input  pe_req, pe_we, pe_addr, pe_wdata,
        output pe_gnt, pe_rvalid, pe_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_last,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout,
        output busy, state_dbg
    );
endinterface

// File: rtl/ma_dmem_arbiter.sv
// Arbiter sharing the single-port MA_DMEM between the MA-stage packet port (PE)
// and the host loader port (LD). Round-robin on ties; LD may lock the memory for
// bursts, but after MAX_BURST consecutive LD beats a waiting PE gets one slot.
module ma_dmem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                  CP,
    input  logic                  MR,
    ma_dmem_arbiter_if.slave      bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {IDLE = 1'b0, LD_LOCK = 1'b1} state_t;
    typedef enum logic [1:0] {RSEL_NONE = 2'd0, RSEL_PE = 2'd1, RSEL_LD = 2'd2} rsel_t;

    state_t            state_q, state_d;
    logic              last_ld_q, last_ld_d;   // last winner: 1=LD, 0=PE
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    rsel_t             rsel_q, rsel_d;
    logic [DATA_W-1:0] pe_rdata_q, ld_rdata_q;
    logic              pe_arb, ld_arb;         // arbitration result, ungated by reset
    logic              pe_gnt, ld_gnt;

    // Arbitration decision and next-state for the IDLE / LD_LOCK FSM
    always_comb begin
        state_d   = state_q;
        last_ld_d = last_ld_q;
        cnt_d     = cnt_q;
        pe_arb    = 1'b0;
        ld_arb    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.pe_req && bus.ld_req) begin
                    pe_arb = last_ld_q;
                    ld_arb = !last_ld_q;
                end else begin
                    pe_arb = bus.pe_req;
                    ld_arb = bus.ld_req;
                end
                if (pe_arb) last_ld_d = 1'b0;
                if (ld_arb) begin
                    last_ld_d = 1'b1;
                    if (!bus.ld_last) begin
                        state_d = LD_LOCK;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            LD_LOCK: begin
                if (cnt_q == CNT_MAX && bus.pe_req) begin
                    // Burst bound reached: PE gets this slot, LD stalls
                    pe_arb = 1'b1;
                    cnt_d  = '0;
                end else if (bus.ld_req) begin
                    ld_arb = 1'b1;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (bus.ld_last) begin
                        state_d   = IDLE;
                        last_ld_d = 1'b1;
                        cnt_d     = '0;
                    end
                end else if (bus.pe_req) begin
                    // Gap fill while LD pauses inside its burst
                    pe_arb = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pe_arb && !bus.pe_we)      rsel_d = RSEL_PE;
        else if (ld_arb && !bus.ld_we) rsel_d = RSEL_LD;
        else                           rsel_d = RSEL_NONE;
    end

    // Grants and memory-side mux; everything forced to 0 while reset is held
    always_comb begin
        pe_gnt = pe_arb && MR;
        ld_gnt = ld_arb && MR;
        bus.pe_gnt   = pe_gnt;
        bus.ld_gnt   = ld_gnt;
        bus.mem_en   = pe_gnt || ld_gnt;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        if (pe_gnt) begin
            bus.mem_we   = bus.pe_we;
            bus.mem_addr = bus.pe_addr;
            bus.mem_din  = bus.pe_wdata;
        end else if (ld_gnt) begin
            bus.mem_we   = bus.ld_we;
            bus.mem_addr = bus.ld_addr;
            bus.mem_din  = bus.ld_wdata;
        end
    end

    // Read-response steering: rdata follows mem_dout in the response cycle, else holds
    always_comb begin
        bus.pe_rvalid = (rsel_q == RSEL_PE);
        bus.ld_rvalid = (rsel_q == RSEL_LD);
        bus.pe_rdata  = bus.pe_rvalid ? bus.mem_dout : pe_rdata_q;
        bus.ld_rdata  = bus.ld_rvalid ? bus.mem_dout : ld_rdata_q;
        bus.busy      = (state_q == LD_LOCK);
        bus.state_dbg = state_q;
    end

    // State, round-robin pointer, burst counter and response registers
    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            state_q    <= IDLE;
            last_ld_q  <= 1'b1;
            cnt_q      <= '0;
            rsel_q     <= RSEL_NONE;
            pe_rdata_q <= '0;
            ld_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_ld_q <= last_ld_d;
            cnt_q     <= cnt_d;
            rsel_q    <= rsel_d;
            if (rsel_q == RSEL_PE) pe_rdata_q <= bus.mem_dout;
            if (rsel_q == RSEL_LD) ld_rdata_q <= bus.mem_dout;
        end
    end
endmodule

// File: tb/tb_ma_dmem_arbiter.sv
// Directed bench for ma_dmem_arbiter: reference memory + read-data scoreboard.
module tb_ma_dmem_arbiter;
    logic CP;
    logic MR;
    int   checks;
    int   failures;

    ma_dmem_arbiter_if #(.ADDR_W(10), .DATA_W(16)) bus ();

    ma_dmem_arbiter #(.ADDR_W(10), .DATA_W(16), .MAX_BURST(8)) dut (
        .CP (CP),
        .MR (MR),
        .bus(bus.slave)
    );

    // Clock
    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    // Memory model: synchronous single port, 1-cycle read latency
    logic [15:0] ram [0:1023];
    always @(posedge CP) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
            else            bus.mem_dout      <= ram[bus.mem_addr];
        end
    end

    // Scoreboard
    logic [15:0] ref_mem [0:1023];
    logic [15:0] pe_exp_q[$];
    logic [15:0] ld_exp_q[$];
    bit          pend_pe;
    bit          pend_ld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check responses due from the previous cycle, check this
    // cycle's grants and memory mux, record the expected transfer, then step.
    task automatic cycle(input bit e_pe, input bit e_ld, input bit e_busy, input string tag);
        logic [15:0] d;
        logic [9:0]  e_addr;
        logic [15:0] e_din;
        logic        e_we;
        @(negedge CP);
        chk({tag, ":pe_rvalid"}, 32'(bus.pe_rvalid), 32'(pend_pe));
        if (pend_pe && pe_exp_q.size() > 0) begin
            d = pe_exp_q.pop_front();
            chk({tag, ":pe_rdata"}, 32'(bus.pe_rdata), 32'(d));
        end
        chk({tag, ":ld_rvalid"}, 32'(bus.ld_rvalid), 32'(pend_ld));
        if (pend_ld && ld_exp_q.size() > 0) begin
            d = ld_exp_q.pop_front();
            chk({tag, ":ld_rdata"}, 32'(bus.ld_rdata), 32'(d));
        end
        chk({tag, ":pe_gnt"}, 32'(bus.pe_gnt), 32'(e_pe));
        chk({tag, ":ld_gnt"}, 32'(bus.ld_gnt), 32'(e_ld));
        chk({tag, ":busy"}, 32'(bus.busy), 32'(e_busy));
        chk({tag, ":state_dbg"}, 32'(bus.state_dbg), 32'(e_busy));
        chk({tag, ":mem_en"}, 32'(bus.mem_en), 32'(e_pe | e_ld));
        e_we   = e_pe ? bus.pe_we    : e_ld ? bus.ld_we    : 1'b0;
        e_addr = e_pe ? bus.pe_addr  : e_ld ? bus.ld_addr  : 10'd0;
        e_din  = e_pe ? bus.pe_wdata : e_ld ? bus.ld_wdata : 16'd0;
        chk({tag, ":mem_we"}, 32'(bus.mem_we), 32'(e_we));
        chk({tag, ":mem_addr"}, 32'(bus.mem_addr), 32'(e_addr));
        chk({tag, ":mem_din"}, 32'(bus.mem_din), 32'(e_din));
        pend_pe = e_pe && !bus.pe_we;
        pend_ld = e_ld && !bus.ld_we;
        if (pend_pe) pe_exp_q.push_back(ref_mem[bus.pe_addr]);
        if (pend_ld) ld_exp_q.push_back(ref_mem[bus.ld_addr]);
        if (e_pe && bus.pe_we) ref_mem[bus.pe_addr] = bus.pe_wdata;
        if (e_ld && bus.ld_we) ref_mem[bus.ld_addr] = bus.ld_wdata;
        @(posedge CP);
        #1;
    endtask

    task automatic drive_pe(input bit req, input bit we, input logic [9:0] addr, input logic [15:0] wdata);
        bus.pe_req   = req;
        bus.pe_we    = we;
        bus.pe_addr  = addr;
        bus.pe_wdata = wdata;
    endtask

    task automatic drive_ld(input bit req, input bit we, input logic [9:0] addr, input logic [15:0] wdata,
                            input bit last);
        bus.ld_req   = req;
        bus.ld_we    = we;
        bus.ld_addr  = addr;
        bus.ld_wdata = wdata;
        bus.ld_last  = last;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":pe_gnt"}, 32'(bus.pe_gnt), 32'd0);
        chk({tag, ":ld_gnt"}, 32'(bus.ld_gnt), 32'd0);
        chk({tag, ":pe_rvalid"}, 32'(bus.pe_rvalid), 32'd0);
        chk({tag, ":ld_rvalid"}, 32'(bus.ld_rvalid), 32'd0);
        chk({tag, ":pe_rdata"}, 32'(bus.pe_rdata), 32'd0);
        chk({tag, ":ld_rdata"}, 32'(bus.ld_rdata), 32'd0);
        chk({tag, ":mem_en"}, 32'(bus.mem_en), 32'd0);
        chk({tag, ":mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, ":mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, ":mem_din"}, 32'(bus.mem_din), 32'd0);
        chk({tag, ":busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Directed sequence
    initial begin
        int pk;
        int lk;
        int beat;
        checks   = 0;
        failures = 0;
        pend_pe  = 1'b0;
        pend_ld  = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;

        // Reset held with both requesters active
        MR = 1'b0;
        drive_pe(1'b1, 1'b1, 10'h010, 16'hA000);
        drive_ld(1'b1, 1'b1, 10'h020, 16'hB000, 1'b1);
        repeat (2) @(posedge CP);
        #1;
        chk_all_zero("reset");
        MR = 1'b1;

        // Tie round-robin with single accesses: PE, LD, PE, LD
        pk = 0;
        lk = 0;
        for (int k = 0; k < 4; k++) begin
            bit e_pe;
            e_pe = (k % 2 == 0);
            cycle(e_pe, !e_pe, 1'b0, "rr");
            if (e_pe) begin
                pk++;
                drive_pe(1'b1, 1'b1, 10'(10'h010 + pk), 16'(16'hA000 + pk));
            end else begin
                lk++;
                drive_ld(1'b1, 1'b1, 10'(10'h020 + lk), 16'(16'hB000 + lk), 1'b1);
            end
        end
        drive_pe(1'b0, 1'b0, 10'h000, 16'h0000);
        drive_ld(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0);

        // Write then read the same address back to back
        drive_pe(1'b1, 1'b1, 10'h005, 16'hBEEF);
        cycle(1'b1, 1'b0, 1'b0, "wr5");
        drive_pe(1'b1, 1'b0, 10'h005, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, "rd5");
        drive_pe(1'b0, 1'b0, 10'h000, 16'h0000);
        cycle(1'b0, 1'b0, 1'b0, "rd5_resp");
        cycle(1'b0, 1'b0, 1'b0, "rd5_hold");
        chk("rd5_hold:pe_rdata", 32'(bus.pe_rdata), 32'h0000BEEF);

        // 12-beat LD burst with PE waiting: 8 LD, 1 PE, 4 LD
        drive_pe(1'b1, 1'b0, 10'h005, 16'h0000);
        beat = 1;
        drive_ld(1'b1, 1'b1, 10'h100, 16'hC001, 1'b0);
        for (int c = 0; c < 13; c++) begin
            bit e_ld;
            e_ld = (c != 8);
            cycle(!e_ld, e_ld, c != 0, "burst");
            if (e_ld) begin
                beat++;
                if (beat > 12) drive_ld(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0);
                else drive_ld(1'b1, 1'b1, 10'(10'h0FF + beat), 16'(16'hC000 + beat), beat == 12);
            end
        end
        cycle(1'b1, 1'b0, 1'b0, "burst_end");
        drive_pe(1'b0, 1'b0, 10'h000, 16'h0000);
        drive_ld(1'b1, 1'b0, 10'h104, 16'h0000, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, "ld_rd");
        drive_ld(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, "ld_rd_resp");

        // Gap fill inside a lock
        drive_ld(1'b1, 1'b1, 10'h1F0, 16'hD001, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, "gap_b1");
        drive_ld(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0);
        drive_pe(1'b1, 1'b1, 10'h200, 16'h1234);
        cycle(1'b1, 1'b0, 1'b1, "gap_fill");
        drive_pe(1'b0, 1'b0, 10'h000, 16'h0000);
        drive_ld(1'b1, 1'b1, 10'h1F1, 16'hD002, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, "gap_b2");
        drive_ld(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, "gap_idle");

        // Reset in the middle of a burst, with an LD read response in flight
        drive_ld(1'b1, 1'b1, 10'h300, 16'hE001, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, "mid_b1");
        drive_ld(1'b1, 1'b1, 10'h301, 16'hE002, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, "mid_b2");
        drive_ld(1'b1, 1'b0, 10'h100, 16'h0000, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, "mid_b3");
        drive_ld(1'b0, 1'b0, 10'h000, 16'h0000, 1'b0);
        #1;
        MR = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        pe_exp_q.delete();
        ld_exp_q.delete();
        pend_pe = 1'b0;
        pend_ld = 1'b0;
        @(posedge CP);
        #1;
        MR = 1'b1;
        drive_pe(1'b1, 1'b0, 10'h005, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, "post_rd");
        drive_pe(1'b0, 1'b0, 10'h000, 16'h0000);
        cycle(1'b0, 1'b0, 1'b0, "post_resp");

        chk("end:pe_exp_q_empty", 32'(pe_exp_q.size()), 32'd0);
        chk("end:ld_exp_q_empty", 32'(ld_exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
